// File: rtl/aes_round_seq.sv
// Round sequencer for an iterative AES-128/192/256 datapath: job handshake, key fetch, round strobes.
// Optional decrypt ordering (dec_i/inv_o ports) is enabled with the AES_DEC_EN macro.
module aes_round_seq #(
   parameter int unsigned NR = 10
) (
   input  logic       clk_i,
   input  logic       res_i,
   input  logic       start_i,
   output logic       busy_o,
   output logic       ld_en_o,
   output logic       key_req_o,
   output logic [3:0] key_idx_o,
   input  logic       key_vld_i,
   output logic       add_en_o,
   output logic       sub_go_o,
   input  logic       sub_done_i,
   output logic       shi_en_o,
   output logic       mix_en_o,
   output logic       out_vld_o,
   input  logic       out_rdy_i,
   output logic [3:0] rnd_o,
   output logic [2:0] cs_o
`ifdef AES_DEC_EN
   ,
   input  logic       dec_i,
   output logic       inv_o
`endif
);

   localparam int unsigned RW = 4;
   localparam logic [RW-1:0] NR_W = RW'(NR);

   typedef enum logic [2:0] {
      IDL = 3'b000,
      LD  = 3'b001,
      ADD = 3'b010,
      SUB = 3'b011,
      SHI = 3'b100,
      MIX = 3'b101,
      FIN = 3'b111
   } state_e;

   state_e        state_q, state_d;
   logic [RW-1:0] rnd_q, rnd_d;
   logic          inv_q, inv_d;
   logic          dec_w;

`ifdef AES_DEC_EN
   assign dec_w = dec_i;
   assign inv_o = inv_q;
`else
   assign dec_w = 1'b0;
`endif

   // Next-state, round counter and direction latch
   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      inv_d   = inv_q;
      case (state_q)
         IDL: begin
            if (start_i) begin
               state_d = LD;
               rnd_d   = '0;
               inv_d   = dec_w;
            end
         end
         LD:  state_d = ADD;
         ADD: begin
            if (key_vld_i) begin
               if (rnd_q == NR_W) begin
                  state_d = FIN;
               end else begin
                  rnd_d = rnd_q + RW'(1);
                  if (inv_q) state_d = (rnd_q == '0) ? SHI : MIX;
                  else       state_d = SUB;
               end
            end
         end
         SUB: begin
            if (sub_done_i) state_d = inv_q ? ADD : SHI;
         end
         SHI: begin
            if (inv_q)              state_d = SUB;
            else if (rnd_q == NR_W) state_d = ADD;
            else                    state_d = MIX;
         end
         MIX: state_d = inv_q ? SHI : ADD;
         FIN: begin
            if (out_rdy_i) begin
               state_d = IDL;
               inv_d   = 1'b0;
            end
         end
         default: state_d = IDL;
      endcase
   end

   // State register with outputs decoded from the next state so they are registered
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q   <= IDL;
         rnd_q     <= '0;
         inv_q     <= 1'b0;
         busy_o    <= 1'b0;
         ld_en_o   <= 1'b0;
         key_req_o <= 1'b0;
         key_idx_o <= '0;
         sub_go_o  <= 1'b0;
         shi_en_o  <= 1'b0;
         mix_en_o  <= 1'b0;
         out_vld_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         inv_q     <= inv_d;
         busy_o    <= (state_d != IDL);
         ld_en_o   <= (state_d == LD);
         key_req_o <= (state_d == ADD);
         key_idx_o <= (state_d != ADD) ? '0 : (inv_d ? (NR_W - rnd_d) : rnd_d);
         sub_go_o  <= (state_d == SUB);
         shi_en_o  <= (state_d == SHI);
         mix_en_o  <= (state_d == MIX);
         out_vld_o <= (state_d == FIN);
      end
   end

   // AddRoundKey fires on the cycle the requested key is presented
   assign add_en_o = key_req_o & key_vld_i;
   assign rnd_o    = rnd_q;
   assign cs_o     = state_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq: table of jobs with stall profiles plus reset/FIN corner sequences.
module tb_aes_round_seq;

   localparam int NR = 10;

   logic       clk_i = 1'b0;
   logic       res_i = 1'b1;
   logic       start_i = 1'b0;
   logic       busy_o, ld_en_o, key_req_o, add_en_o, sub_go_o, shi_en_o, mix_en_o, out_vld_o;
   logic [3:0] key_idx_o, rnd_o;
   logic [2:0] cs_o;
   logic       key_vld_i = 1'b1;
   logic       sub_done_i = 1'b1;
   logic       out_rdy_i = 1'b1;
   logic       dec_i = 1'b0;
`ifdef AES_DEC_EN
   logic       inv_o;
`endif

   aes_round_seq #(.NR(NR)) dut (
      .clk_i(clk_i), .res_i(res_i), .start_i(start_i), .busy_o(busy_o), .ld_en_o(ld_en_o),
      .key_req_o(key_req_o), .key_idx_o(key_idx_o), .key_vld_i(key_vld_i), .add_en_o(add_en_o),
      .sub_go_o(sub_go_o), .sub_done_i(sub_done_i), .shi_en_o(shi_en_o), .mix_en_o(mix_en_o),
      .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .rnd_o(rnd_o), .cs_o(cs_o)
`ifdef AES_DEC_EN
      , .dec_i(dec_i), .inv_o(inv_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit dec;
      int stall_rnd;
      int stall_len;
      int sub_dly;
      int lat;
   } vec_t;

   typedef struct {
      bit dec;
      int lat;
      int n_ld;
      int n_add;
      int n_shi;
      int n_mix;
      int n_sub;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   int   cfg_stall_rnd = -1;
   int   stall_left = 0;
   int   cfg_sub_dly = 0;
   int   sub_cnt = 0;
   bit   stall_now = 1'b0;
   bit   cur_dec = 1'b0;

   int   cnt_ld = 0, cnt_add = 0, cnt_shi = 0, cnt_mix = 0, cnt_sub = 0;
   int   kseq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Key-schedule and S-box responders, driven just after each rising edge
   always @(posedge clk_i) begin
      #1;
      stall_now = 1'b0;
      if (cs_o == 3'b010 && int'(rnd_o) == cfg_stall_rnd && stall_left > 0) begin
         key_vld_i = 1'b0;
         stall_now = 1'b1;
         stall_left--;
      end else begin
         key_vld_i = 1'b1;
      end
      if (cs_o == 3'b011) begin
         sub_done_i = (sub_cnt >= cfg_sub_dly);
         sub_cnt++;
      end else begin
         sub_done_i = 1'b1;
         sub_cnt = 0;
      end
   end

   // Strobe counters, key index log and in-stall checks, sampled mid-cycle
   always @(negedge clk_i) begin
      if (!res_i) begin
         if (ld_en_o)  cnt_ld++;
         if (shi_en_o) cnt_shi++;
         if (mix_en_o) cnt_mix++;
         if (sub_go_o) cnt_sub++;
         if (add_en_o) begin
            cnt_add++;
            kseq.push_back(int'(key_idx_o));
         end
         if (stall_now) begin
            chk("stall_add_en", 32'(add_en_o), 32'd0);
            chk("stall_cs", 32'(cs_o), 32'd2);
            chk("stall_rnd", 32'(rnd_o), 32'(cfg_stall_rnd));
         end
`ifdef AES_DEC_EN
         if (busy_o && cs_o != 3'b001) chk("inv_held", 32'(inv_o), 32'(cur_dec));
`endif
      end
   end

   task automatic run_job(input vec_t v);
      exp_t e, got;
      int   k, ld0, add0, shi0, mix0, sub0, kq0, bad;
      cfg_stall_rnd = v.stall_rnd;
      stall_left    = v.stall_len;
      cfg_sub_dly   = v.sub_dly;
      cur_dec       = v.dec;
      e = '{dec: v.dec, lat: v.lat, n_ld: 1, n_add: NR + 1, n_shi: NR, n_mix: NR - 1,
            n_sub: NR * (v.sub_dly + 1)};
      sb.push_back(e);
      ld0 = cnt_ld; add0 = cnt_add; shi0 = cnt_shi; mix0 = cnt_mix; sub0 = cnt_sub;
      kq0 = kseq.size();
      @(posedge clk_i);
      #1;
      dec_i   = v.dec;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      dec_i   = 1'b0;
      k = 0;
      while (1) begin
         @(negedge clk_i);
         if (out_vld_o || k >= 2000) break;
         @(posedge clk_i);
         k++;
      end
      got = sb.pop_front();
      chk("out_vld_seen", 32'(out_vld_o), 32'd1);
      chk("latency", 32'(k), 32'(got.lat));
      chk("n_ld", 32'(cnt_ld - ld0), 32'(got.n_ld));
      chk("n_add", 32'(cnt_add - add0), 32'(got.n_add));
      chk("n_shi", 32'(cnt_shi - shi0), 32'(got.n_shi));
      chk("n_mix", 32'(cnt_mix - mix0), 32'(got.n_mix));
      chk("n_subgo", 32'(cnt_sub - sub0), 32'(got.n_sub));
      bad = 0;
      for (int i = 0; i < got.n_add && kq0 + i < kseq.size(); i++)
         if (kseq[kq0 + i] != (got.dec ? NR - i : i)) bad++;
      chk("key_idx_seq", 32'(bad), 32'd0);
      chk("fin_cs", 32'(cs_o), 32'd7);
      chk("fin_busy", 32'(busy_o), 32'd1);
   endtask

`ifdef AES_DEC_EN
   localparam int NVEC = 6;
`else
   localparam int NVEC = 4;
`endif

   initial begin
      vec_t vt[NVEC];
      int   k;
      vt[0] = '{dec: 1'b0, stall_rnd: -1, stall_len: 0, sub_dly: 0, lat: 4 * NR + 1};
      vt[1] = '{dec: 1'b0, stall_rnd: 3,  stall_len: 5, sub_dly: 0, lat: 4 * NR + 6};
      vt[2] = '{dec: 1'b0, stall_rnd: -1, stall_len: 0, sub_dly: 3, lat: 4 * NR + 1 + 3 * NR};
      vt[3] = '{dec: 1'b0, stall_rnd: 2,  stall_len: 2, sub_dly: 1, lat: 4 * NR + 1 + 2 + NR};
`ifdef AES_DEC_EN
      vt[4] = '{dec: 1'b1, stall_rnd: -1, stall_len: 0, sub_dly: 0, lat: 4 * NR + 1};
      vt[5] = '{dec: 1'b1, stall_rnd: 4,  stall_len: 3, sub_dly: 2, lat: 4 * NR + 1 + 3 + 2 * NR};
`endif

      // Reset values
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_cs", 32'(cs_o), 32'd0);
      chk("rst_rnd", 32'(rnd_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_strobes", 32'({ld_en_o, add_en_o, shi_en_o, mix_en_o, sub_go_o, key_req_o}), 32'd0);
      chk("rst_out_vld", 32'(out_vld_o), 32'd0);
      @(posedge clk_i);
      #1;
      res_i = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         run_job(vt[i]);
         @(negedge clk_i);
         chk("post_idle_cs", 32'(cs_o), 32'd0);
      end

      // Result held in FIN while downstream stalls; start during FIN is not queued
      out_rdy_i = 1'b0;
      run_job(vt[0]);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk_i);
         #1;
         start_i = (i % 2 == 0);
         @(negedge clk_i);
         chk("hold_out_vld", 32'(out_vld_o), 32'd1);
         chk("hold_cs", 32'(cs_o), 32'd7);
      end
      @(posedge clk_i);
      #1;
      start_i   = 1'b0;
      out_rdy_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("rel_cs", 32'(cs_o), 32'd0);
      chk("rel_busy", 32'(busy_o), 32'd0);
      chk("rel_out_vld", 32'(out_vld_o), 32'd0);
      @(negedge clk_i);
      chk("no_queued_job", 32'(busy_o), 32'd0);

      // Reset taken in SHI of round 5
      cfg_stall_rnd = -1;
      stall_left    = 0;
      cfg_sub_dly   = 0;
      cur_dec       = 1'b0;
      @(posedge clk_i);
      #1;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      k = 0;
      while (k < 200) begin
         @(negedge clk_i);
         if (cs_o == 3'b100 && rnd_o == 4'd5) break;
         k++;
      end
      chk("reached_shi5", 32'(k < 200), 32'd1);
      res_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("mid_rst_cs", 32'(cs_o), 32'd0);
      chk("mid_rst_rnd", 32'(rnd_o), 32'd0);
      chk("mid_rst_outs", 32'({busy_o, ld_en_o, add_en_o, shi_en_o, mix_en_o, sub_go_o,
                               key_req_o, out_vld_o, key_idx_o}), 32'd0);
      @(posedge clk_i);
      #1;
      res_i = 1'b0;
      run_job(vt[0]);
      @(negedge clk_i);
      chk("final_idle", 32'(cs_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
